// File: rtl/io_flag_unit.sv
// Character I/O block of the basic computer. It holds INPR/OUTR and the FGI/FGO flags,
// with a small RX FIFO feeding INPR and a valid/ready transmit path driven from OUTR.
module io_flag_unit #(
    parameter int RX_DEPTH = 4,
    parameter int DW       = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [15:0]   bus_in,
    input  logic          inputr_s,
    input  logic [2:0]    outr_s,
    input  logic          ien,
    output logic [DW-1:0] inpr,
    output logic          fgi,
    output logic          fgo,
    output logic          int_req,
    input  logic [DW-1:0] ext_rx_data,
    input  logic          ext_rx_valid,
    output logic          ext_rx_ready,
    output logic [DW-1:0] ext_tx_data,
    output logic          ext_tx_valid,
    input  logic          ext_tx_ready,
    output logic          overrun
);
    localparam int AW = $clog2(RX_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(RX_DEPTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [DW-1:0] rx_mem [RX_DEPTH];

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          rx_ready_q, rx_ready_d;
    logic [DW-1:0] inpr_q, inpr_d;
    logic          fgi_q, fgi_d;
    logic [DW-1:0] outr_q, outr_d;
    logic [0:0]    state_q, state_d;
    logic          overrun_q, overrun_d;
    logic          inputr_s_q, out_sel_q;

    logic out_sel, inp_ev, out_ev, push, pop;

    // Upper bus bits carry no meaning for an 8-bit character.
    logic unused_bus_hi;
    assign unused_bus_hi = ^bus_in[15:DW];

    always_comb begin
        out_sel = (outr_s == 3'b100);
        inp_ev  = inputr_s & ~inputr_s_q;
        out_ev  = out_sel & ~out_sel_q;
        push    = ext_rx_valid & rx_ready_q;
        // A pending INP blocks the reload so AC still sees the old character.
        pop     = ~fgi_q & (count_q != '0) & ~inp_ev;

        wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop  ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        rx_ready_d = (count_d != FULL_COUNT);

        inpr_d = inpr_q;
        fgi_d  = fgi_q;
        if (pop) begin
            inpr_d = rx_mem[rptr_q];
            fgi_d  = 1'b1;
        end else if (inp_ev) begin
            fgi_d = 1'b0;
        end

        outr_d    = outr_q;
        state_d   = state_q;
        overrun_d = overrun_q;
        case (state_q)
            ST_IDLE: begin
                if (out_ev) begin
                    outr_d  = bus_in[DW-1:0];
                    state_d = ST_SEND;
                end
            end
            default: begin
                if (out_ev) begin
                    overrun_d = 1'b1;
                end
                if (ext_tx_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rx_mem[wptr_q] <= ext_rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            rx_ready_q <= 1'b0;
            inpr_q     <= '0;
            fgi_q      <= 1'b0;
            outr_q     <= '0;
            state_q    <= ST_IDLE;
            overrun_q  <= 1'b0;
            inputr_s_q <= 1'b0;
            out_sel_q  <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            rx_ready_q <= rx_ready_d;
            inpr_q     <= inpr_d;
            fgi_q      <= fgi_d;
            outr_q     <= outr_d;
            state_q    <= state_d;
            overrun_q  <= overrun_d;
            inputr_s_q <= inputr_s;
            out_sel_q  <= out_sel;
        end
    end

    assign inpr         = inpr_q;
    assign fgi          = fgi_q;
    assign fgo          = (state_q == ST_IDLE);
    assign int_req      = ien & (fgi_q | fgo);
    assign ext_rx_ready = rx_ready_q;
    assign ext_tx_data  = outr_q;
    assign ext_tx_valid = (state_q == ST_SEND);
    assign overrun      = overrun_q;
endmodule

// File: tb/tb_io_flag_unit.sv
// Bench for io_flag_unit: directed literal checks from the test plan, then random traffic
// compared every cycle against a queue-based behavioural model.
module tb_io_flag_unit;
    localparam int DEPTH = 4;
    localparam int DW    = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   bus_in;
    logic          inputr_s;
    logic [2:0]    outr_s;
    logic          ien;
    logic [DW-1:0] inpr;
    logic          fgi, fgo, int_req;
    logic [DW-1:0] ext_rx_data;
    logic          ext_rx_valid, ext_rx_ready;
    logic [DW-1:0] ext_tx_data;
    logic          ext_tx_valid, ext_tx_ready;
    logic          overrun;

    int vectors    = 0;
    int miscompares = 0;

    io_flag_unit #(.RX_DEPTH(DEPTH), .DW(DW)) dut (
        .clk(clk), .reset(reset), .bus_in(bus_in), .inputr_s(inputr_s),
        .outr_s(outr_s), .ien(ien), .inpr(inpr), .fgi(fgi), .fgo(fgo),
        .int_req(int_req), .ext_rx_data(ext_rx_data), .ext_rx_valid(ext_rx_valid),
        .ext_rx_ready(ext_rx_ready), .ext_tx_data(ext_tx_data),
        .ext_tx_valid(ext_tx_valid), .ext_tx_ready(ext_tx_ready), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: the RX FIFO is a plain queue, the transmitter is just "busy or not".
    logic [DW-1:0] m_fifo[$];
    logic [DW-1:0] m_inpr, m_outr;
    logic          m_fgi, m_fgo, m_overrun, m_ready;
    logic          m_prev_inp, m_prev_out;
    logic          m_valid = 1'b0;

    always @(posedge clk) begin
        logic ev_inp, ev_out, do_push, do_pop;
        if (reset) begin
            m_fifo.delete();
            m_inpr = '0; m_outr = '0; m_fgi = 1'b0; m_fgo = 1'b1;
            m_overrun = 1'b0; m_ready = 1'b0; m_prev_inp = 1'b0; m_prev_out = 1'b0;
        end else begin
            ev_inp  = inputr_s && !m_prev_inp;
            ev_out  = (outr_s == 3'b100) && !m_prev_out;
            do_push = ext_rx_valid && m_ready;
            do_pop  = !m_fgi && (m_fifo.size() > 0) && !ev_inp;
            if (do_pop) begin
                m_inpr = m_fifo.pop_front();
                m_fgi  = 1'b1;
            end
            if (ev_inp) m_fgi = 1'b0;
            if (do_push) m_fifo.push_back(ext_rx_data);
            m_ready = (m_fifo.size() < DEPTH);
            if (m_fgo) begin
                if (ev_out) begin
                    m_outr = bus_in[DW-1:0];
                    m_fgo  = 1'b0;
                end
            end else begin
                if (ev_out) m_overrun = 1'b1;
                if (ext_tx_ready) m_fgo = 1'b1;
            end
            m_prev_inp = inputr_s;
            m_prev_out = (outr_s == 3'b100);
        end
        m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("inpr", 16'(inpr), 16'(m_inpr));
            check("fgi", 16'(fgi), 16'(m_fgi));
            check("fgo", 16'(fgo), 16'(m_fgo));
            check("int_req", 16'(int_req), 16'(ien & (m_fgi | m_fgo)));
            check("ext_rx_ready", 16'(ext_rx_ready), 16'(m_ready));
            check("ext_tx_data", 16'(ext_tx_data), 16'(m_outr));
            check("ext_tx_valid", 16'(ext_tx_valid), 16'(!m_fgo));
            check("overrun", 16'(overrun), 16'(m_overrun));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic inp_strobe(input logic [7:0] exp_inpr);
        inputr_s = 1'b1;
        tick();
        inputr_s = 1'b0;
        tick();
        tick();
        check("inp_seq_inpr", 16'(inpr), 16'(exp_inpr));
        check("inp_seq_fgi", 16'(fgi), 16'd1);
    endtask

    initial begin
        reset = 1'b1; bus_in = '0; inputr_s = 1'b0; outr_s = 3'b000; ien = 1'b0;
        ext_rx_data = 8'h99; ext_rx_valid = 1'b1; ext_tx_ready = 1'b0;
        tick();
        tick();
        check("reset_rx_ready", 16'(ext_rx_ready), 16'd0);
        reset = 1'b0; ext_rx_valid = 1'b0;
        tick();
        check("rst_fgi", 16'(fgi), 16'd0);
        check("rst_fgo", 16'(fgo), 16'd1);
        check("rst_inpr", 16'(inpr), 16'd0);
        check("rst_tx_valid", 16'(ext_tx_valid), 16'd0);
        check("rst_int_req", 16'(int_req), 16'd0);
        check("rst_rx_ready", 16'(ext_rx_ready), 16'd1);

        ien = 1'b1;
        #1 check("int_fgo", 16'(int_req), 16'd1);

        // Transmit: strobe held two cycles gives a single load.
        bus_in = 16'h1234; outr_s = 3'b100;
        tick();
        tick();
        outr_s = 3'b000;
        check("tx_data", 16'(ext_tx_data), 16'h0034);
        check("tx_fgo", 16'(fgo), 16'd0);
        check("tx_int_req", 16'(int_req), 16'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("tx_hold_valid", 16'(ext_tx_valid), 16'd1);
            check("tx_hold_data", 16'(ext_tx_data), 16'h0034);
        end
        bus_in = 16'h0055; outr_s = 3'b100;
        tick();
        outr_s = 3'b000;
        check("ovr_data", 16'(ext_tx_data), 16'h0034);
        check("ovr_flag", 16'(overrun), 16'd1);

        // Single receive: two edges from acceptance to fgi.
        ext_rx_data = 8'h41; ext_rx_valid = 1'b1;
        tick();
        ext_rx_valid = 1'b0;
        check("rx_fgi_early", 16'(fgi), 16'd0);
        tick();
        check("rx_fgi", 16'(fgi), 16'd1);
        check("rx_inpr", 16'(inpr), 16'h0041);
        check("rx_int_req", 16'(int_req), 16'd1);
        ien = 1'b0;
        #1 check("ien_off", 16'(int_req), 16'd0);

        inputr_s = 1'b1;
        tick();
        check("inp_fgi_clr", 16'(fgi), 16'd0);
        tick();
        tick();
        inputr_s = 1'b0;
        check("inp_hold_fgi", 16'(fgi), 16'd0);
        check("inp_hold_inpr", 16'(inpr), 16'h0041);

        ext_tx_ready = 1'b1;
        tick();
        ext_tx_ready = 1'b0;
        check("tx_done_fgo", 16'(fgo), 16'd1);
        check("tx_done_valid", 16'(ext_tx_valid), 16'd0);
        check("ovr_sticky", 16'(overrun), 16'd1);

        // FIFO fill: five characters into a four-entry FIFO plus INPR.
        ext_rx_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            ext_rx_data = 8'(i);
            tick();
        end
        ext_rx_data = 8'h06;
        tick();
        tick();
        ext_rx_valid = 1'b0;
        check("fill_inpr", 16'(inpr), 16'h0001);
        check("fill_ready", 16'(ext_rx_ready), 16'd0);
        for (int i = 2; i <= 5; i++) begin
            inp_strobe(8'(i));
        end
        ext_rx_data = 8'h06; ext_rx_valid = 1'b1;
        tick();
        ext_rx_valid = 1'b0;
        inp_strobe(8'h06);

        // Random traffic with occasional mid-transfer resets.
        for (int c = 0; c < 4000; c++) begin
            reset        = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 5) == 0) inputr_s = ~inputr_s;
            case ($urandom_range(0, 9))
                0, 1:    outr_s = (outr_s == 3'b100) ? 3'b000 : 3'b100;
                2:       outr_s = 3'($urandom);
                default: outr_s = outr_s;
            endcase
            bus_in       = 16'($urandom);
            ien          = 1'($urandom);
            ext_rx_data  = 8'($urandom);
            ext_rx_valid = ($urandom_range(0, 2) != 0);
            ext_tx_ready = ($urandom_range(0, 3) == 0);
            tick();
        end
        reset = 1'b0;
        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
